// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor controller.
package serial_add_pkg;

  // Encoding 2'd3 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder cell; the serial controller reuses it once per clock.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: sequences fa_cell over WIDTH bits, LSB first,
// with the carry held in a flop between cycles and a registered result.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           state_dbg
);

  localparam int CW = cnt_w(WIDTH);

  // Handshake: start is sampled only in IDLE and captures a/b/cin/sub at that
  // edge; busy stays high until IDLE returns; done is a one-cycle Moore pulse
  // during which sum/cout/ovf are valid (they then hold until the next done).

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx, s_ext;
  logic [CW-1:0]    cnt;
  logic             carry, s_bit, c_nx, last;

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (carry),
    .s  (s_bit),
    .co (c_nx)
  );

  assign last      = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign s_ext     = WIDTH'(s_bit);
  assign res_nx    = (res_sh >> 1) | (s_ext << (WIDTH - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, so the incoming carry is forced high.
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nx;
          carry  <= c_nx;
          if (last) begin
            sum  <= res_nx;
            cout <= c_nx;
            // carry still holds the carry into the MSB during the last bit
            ovf  <= carry ^ c_nx;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl at WIDTH=4 and WIDTH=1,
// checked against an arithmetic reference model and an expected-result queue.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic         start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  state_t       dbg;

  // WIDTH=1 instance
  logic   start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic   a1 = 1'b0, b1 = 1'b0;
  logic   busy1, done1, sum1, cout1, ovf1;
  state_t dbg1;

  serial_add_ctrl #(.WIDTH(W)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .state_dbg(dbg)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1), .state_dbg(dbg1)
  );

  // scoreboard: {ovf, cout, sum}
  int           n_vec = 0;
  int           n_bad = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_res = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plain arithmetic: result = a + (sub ? -b : b) (+cin for add), modulo 2^w.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic su);
    longint unsigned mask, xa, yb, t;
    logic [33:0] r;
    mask = (64'd1 << w) - 64'd1;
    xa   = {32'b0, x} & mask;
    yb   = su ? (~{32'b0, y} & mask) : ({32'b0, y} & mask);
    t    = xa + yb + (su ? 64'd1 : {63'b0, ci});
    r        = '0;
    r[31:0]  = 32'(t & mask);
    r[32]    = t[w];
    r[33]    = (xa[w-1] == yb[w-1]) && (t[w-1] != xa[w-1]);
    return r;
  endfunction

  task automatic push4(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci, input logic si);
    logic [33:0] m;
    m = model(W, 32'(ai), 32'(bi), ci, si);
    exp_q.push_back({m[33], m[32], m[W-1:0]});
  endtask

  task automatic check_done4();
    logic [W+1:0] r;
    if (exp_q.size() == 0) begin
      chk("spurious_done", done, 1'b0);
    end else begin
      r = exp_q.pop_front();
      chk("sum", sum, r[W-1:0]);
      chk("cout", cout, r[W]);
      chk("ovf", ovf, r[W+1]);
      last_res = r;
    end
  endtask

  task automatic run_op4(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci, input logic si);
    int n;
    @(posedge clk); #1;
    a = ai; b = bi; cin = ci; sub = si; start = 1'b1;
    push4(ai, bi, ci, si);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk("busy_run", busy, 1'b1);
    chk("hold_sum", {ovf, cout, sum}, last_res);
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, W + 1);
    if (done) check_done4();
    else exp_q.delete();
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic run_op1(input logic ai, input logic bi, input logic ci, input logic si);
    logic [33:0] m;
    int n;
    m = model(1, {31'b0, ai}, {31'b0, bi}, ci, si);
    @(posedge clk); #1;
    a1 = ai; b1 = bi; cin1 = ci; sub1 = si; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("w1_busy", busy1, 1'b1);
    n = 1;
    while (!done1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w1_latency", n, 2);
    chk("w1_sum", sum1, m[0]);
    chk("w1_cout", cout1, m[32]);
    chk("w1_ovf", ovf1, m[33]);
    @(posedge clk); #1;
    chk("w1_done_pulse", done1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, gap, cnt_d;
    logic [W-1:0] a2, b2;
    logic c2, s2;

    // asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_state", dbg, IDLE);
    chk("rst_state_w1", dbg1, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // directed arithmetic
    run_op4(4'b0011, 4'b0101, 1'b0, 1'b0);
    run_op4(4'b1111, 4'b0001, 1'b1, 1'b0);
    run_op4(4'b0111, 4'b0001, 1'b0, 1'b0);
    run_op4(4'b0101, 4'b0011, 1'b1, 1'b1);
    run_op4(4'b0011, 4'b0101, 1'b0, 1'b1);

    // start held high, operands changed during RUN
    @(posedge clk); #1;
    a = 4'b0110; b = 4'b0011; cin = 1'b1; sub = 1'b0; start = 1'b1;
    push4(4'b0110, 4'b0011, 1'b1, 1'b0);
    @(posedge clk); #1;
    a2 = W'($urandom); b2 = W'($urandom); c2 = 1'($urandom); s2 = 1'($urandom);
    a = a2; b = b2; cin = c2; sub = s2;
    push4(a2, b2, c2, s2);
    first = -1; gap = 0; cnt_d = 0;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (cnt_d == 0) first = i;
        else gap = i - first;
        cnt_d++;
        check_done4();
      end
    end
    start = 1'b0;
    chk("hs_done_count", cnt_d, 2);
    chk("hs_first", first, W);
    chk("hs_gap", gap, W + 2);
    exp_q.delete();

    // abort after two RUN cycles
    @(posedge clk); #1;
    a = 4'b1001; b = 4'b0100; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_nodone_a", done, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sum", sum, '0);
    chk("abort_cout", cout, 1'b0);
    chk("abort_ovf", ovf, 1'b0);
    last_res = '0;
    @(posedge clk); #1;
    chk("abort_nodone_b", done, 1'b0);
    rst = 1'b0;
    run_op4(4'b1001, 4'b0100, 1'b1, 1'b0);

    // randomized operations
    for (int i = 0; i < 24; i++)
      run_op4(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // WIDTH=1: full-adder truth table, then subtract combinations
    for (int v = 0; v < 8; v++) run_op1(v[2], v[1], v[0], 1'b0);
    for (int v = 0; v < 4; v++) run_op1(v[1], v[0], 1'($urandom), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
